// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO bank.
//   - register word indices (addr[4:2] within the 32-byte window)
//   - bus size encodings
//   - lane helper: byte/half/word mask and shift for a given size and addr[1:0]
package gpio_pkg;

    localparam logic [2:0] REG_OUT    = 3'd0;
    localparam logic [2:0] REG_IN     = 3'd1;
    localparam logic [2:0] REG_EDGE   = 3'd2;
    localparam logic [2:0] REG_IRQ_EN = 3'd3;
    localparam logic [2:0] REG_SET    = 3'd4;
    localparam logic [2:0] REG_CLR    = 3'd5;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef struct packed {
        logic [31:0] mask;   // bits of the 32-bit register touched by the access
        logic [4:0]  shift;  // bit position of the addressed lane
    } lane_t;

    function automatic lane_t lane_of(input logic [1:0] size, input logic [1:0] lo);
        lane_t l;
        l.mask  = '0;
        l.shift = '0;
        case (size)
            SZ_BYTE: begin
                l.shift = {lo, 3'b000};
                l.mask  = 32'h0000_00FF << l.shift;
            end
            SZ_HALF: begin
                l.shift = {lo[1], 4'b0000};
                l.mask  = 32'h0000_FFFF << l.shift;
            end
            SZ_WORD: l.mask = '1;
            default: ;
        endcase
        return l;
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return !lo[0];
            SZ_WORD: return lo == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank_if: CPU data-bus port of the GPIO bank.
//   addr/wdata/rw/size : request from the CPU (master)
//   rdata/rdata_valid  : registered read response from the peripheral (slave)
interface gpio_bank_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rw;
    logic [1:0]  size;

    modport master (
        output addr, wdata, rw, size,
        input  rdata, rdata_valid
    );

    modport slave (
        input  addr, wdata, rw, size,
        output rdata, rdata_valid
    );
endinterface

// File: rtl/gpio_in_cond.sv
// gpio_in_cond: input conditioning for a bank of W asynchronous inputs.
//   clk, rst_n : clock, synchronous active-low reset
//   din_i      : raw asynchronous inputs
//   level_o    : debounced level (the IN register)
//   edge_o     : one-cycle pulse per bit, high in the cycle level_o is about to change
// Two-flop synchroniser, then a sample taken every SAMPLE_DIV cycles; a bit is
// accepted only when two consecutive samples agree.
module gpio_in_cond #(
    parameter int unsigned W          = 10,
    parameter int unsigned SAMPLE_DIV = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] edge_o
);
    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [W-1:0]    s1_q, s2_q, sample_q, sample_d, level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick;
    logic [W-1:0]    stable;

    always_comb begin
        tick     = (cnt_q == CntW'(SAMPLE_DIV - 1));
        cnt_d    = tick ? '0 : cnt_q + CntW'(1);
        stable   = ~(s2_q ^ sample_q);
        sample_d = sample_q;
        level_d  = level_q;
        if (tick) begin
            sample_d = s2_q;
            // Per bit: accept only where this sample matches the previous one.
            level_d  = (level_q & ~stable) | (s2_q & stable);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            sample_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= din_i;
            s2_q     <= s1_q;
            sample_q <= sample_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign edge_o  = level_d ^ level_q;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO peripheral with a 32-byte register window.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : CPU bus (addr, wdata, rw, size in; rdata, rdata_valid out)
//   gpio_in    : asynchronous inputs, conditioned by gpio_in_cond
//   gpio_out   : OUT register
//   irq        : |(EDGE & IRQ_EN)
// Registers: OUT, IN (RO), EDGE (W1C), IRQ_EN, SET/CLR (WO, read 0), two reserved.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter logic [31:0] IO_ADDR    = 32'h8000_0000,
    parameter int unsigned OUT_W      = 10,
    parameter int unsigned IN_W       = 10,
    parameter int unsigned SAMPLE_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_bank_if.slave       bus,
    input  logic [IN_W-1:0]  gpio_in,
    output logic [OUT_W-1:0] gpio_out,
    output logic             irq
);
    logic [OUT_W-1:0] out_q, out_d;
    logic [IN_W-1:0]  edge_q, edge_d;
    logic [IN_W-1:0]  irq_en_q, irq_en_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q;

    logic [IN_W-1:0]  in_level, in_pulse;

    logic [31:0]      offset;
    logic [2:0]       idx;
    logic             in_window, aligned, wr_en, rd_en;
    lane_t            lane;
    logic [31:0]      wval, rd_word;
    logic [OUT_W-1:0] wval_out, mask_out;
    logic [IN_W-1:0]  wval_in, mask_in, edge_clr;

    gpio_in_cond #(
        .W         (IN_W),
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_in_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (gpio_in),
        .level_o(in_level),
        .edge_o (in_pulse)
    );

    always_comb begin
        // Subtraction wraps for addresses below the base, so check both bounds.
        offset    = bus.addr - IO_ADDR;
        in_window = (bus.addr >= IO_ADDR) && (offset < 32'd32);
        idx       = offset[4:2];
        aligned   = is_aligned(bus.size, bus.addr[1:0]);
        lane      = lane_of(bus.size, bus.addr[1:0]);
        wr_en     = (bus.size != SZ_NONE) && in_window && bus.rw && aligned;
        rd_en     = (bus.size != SZ_NONE) && in_window && !bus.rw;

        // Write data placed in its lane; bits outside the lane are zero.
        wval      = (bus.wdata << lane.shift) & lane.mask;
        wval_out  = OUT_W'(wval);
        mask_out  = OUT_W'(lane.mask);
        wval_in   = IN_W'(wval);
        mask_in   = IN_W'(lane.mask);

        out_d     = out_q;
        irq_en_d  = irq_en_q;
        edge_clr  = '0;
        if (wr_en) begin
            case (idx)
                REG_OUT:    out_d    = (out_q & ~mask_out) | wval_out;
                REG_SET:    out_d    = out_q | wval_out;
                REG_CLR:    out_d    = out_q & ~wval_out;
                REG_IRQ_EN: irq_en_d = (irq_en_q & ~mask_in) | wval_in;
                REG_EDGE:   edge_clr = wval_in;
                default: ;
            endcase
        end
        // A new edge in the same cycle as a W1C keeps the bit set.
        edge_d    = (edge_q & ~edge_clr) | in_pulse;

        case (idx)
            REG_OUT:    rd_word = 32'(out_q);
            REG_IN:     rd_word = 32'(in_level);
            REG_EDGE:   rd_word = 32'(edge_q);
            REG_IRQ_EN: rd_word = 32'(irq_en_q);
            default:    rd_word = '0;
        endcase

        rdata_d   = rdata_q;
        if (rd_en) begin
            rdata_d = aligned ? (rd_word >> lane.shift) & (lane.mask >> lane.shift) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q         <= '0;
            edge_q        <= '0;
            irq_en_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            out_q         <= out_d;
            edge_q        <= edge_d;
            irq_en_q      <= irq_en_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rd_en;
        end
    end

    assign gpio_out        = out_q;
    assign irq             = |(edge_q & irq_en_q);
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank. u_dut1 (SAMPLE_DIV=1) covers reset and input latency;
// u_dut4 (SAMPLE_DIV=4) covers the bus, debounce, edge/irq and decode behaviour.
module tb_gpio_bank;
    import gpio_pkg::*;

    localparam logic [31:0] A_OUT  = 32'h8000_0000;
    localparam logic [31:0] A_IN   = 32'h8000_0004;
    localparam logic [31:0] A_EDGE = 32'h8000_0008;
    localparam logic [31:0] A_IEN  = 32'h8000_000C;
    localparam logic [31:0] A_SET  = 32'h8000_0010;
    localparam logic [31:0] A_CLR  = 32'h8000_0014;
    localparam logic [31:0] A_RSV  = 32'h8000_0018;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] gin1, gin4, gout1, gout4;
    logic       irq1, irq4;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    gpio_bank_if bus1 ();
    gpio_bank_if bus4 ();

    gpio_bank #(
        .IO_ADDR(32'h8000_0000), .OUT_W(10), .IN_W(10), .SAMPLE_DIV(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .gpio_in(gin1), .gpio_out(gout1), .irq(irq1)
    );

    gpio_bank #(
        .IO_ADDR(32'h8000_0000), .OUT_W(10), .IN_W(10), .SAMPLE_DIV(4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .gpio_in(gin4), .gpio_out(gout4), .irq(irq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus4.addr  = a;
        bus4.wdata = d;
        bus4.rw    = 1'b1;
        bus4.size  = sz;
        @(negedge clk);
        bus4.size  = SZ_NONE;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz,
                      output logic [31:0] d, output logic v);
        bus4.addr = a;
        bus4.rw   = 1'b0;
        bus4.size = sz;
        @(negedge clk);
        d         = bus4.rdata;
        v         = bus4.rdata_valid;
        bus4.size = SZ_NONE;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic        v;
        logic        found;

        rst_n      = 1'b0;
        gin1       = 10'h3FF;
        gin4       = 10'h000;
        bus1.addr  = '0; bus1.wdata = '0; bus1.rw = 1'b0; bus1.size = SZ_NONE;
        bus4.addr  = '0; bus4.wdata = '0; bus4.rw = 1'b0; bus4.size = SZ_NONE;

        // Reset held for two rising edges.
        repeat (2) @(negedge clk);
        check("rst_gout1", 32'(gout1), 32'h0);
        check("rst_irq1", 32'(irq1), 32'h0);
        check("rst_valid1", 32'(bus1.rdata_valid), 32'h0);
        check("rst_gout4", 32'(gout4), 32'h0);
        check("rst_irq4", 32'(irq4), 32'h0);
        check("rst_rdata4", bus4.rdata, 32'h0);
        rst_n = 1'b1;

        // IN on the SAMPLE_DIV=1 instance must reach 0x3FF within 6 back-to-back reads.
        d = '0;
        for (int i = 0; i < 6; i++) begin
            bus1.addr = A_IN; bus1.rw = 1'b0; bus1.size = SZ_WORD;
            @(negedge clk);
            d = bus1.rdata;
            if (bus1.rdata_valid && d == 32'h3FF) break;
        end
        bus1.size = SZ_NONE;
        check("in_latency", d, 32'h3FF);

        // Lane writes. Byte lane 1 covers bits 15:8, so only OUT[9:8] change.
        wr(A_OUT, 32'h155, SZ_WORD);
        check("out_word", 32'(gout4), 32'h155);
        wr(A_OUT + 32'd1, 32'hFF, SZ_BYTE);
        check("out_byte1", 32'(gout4), 32'h355);
        wr(A_OUT + 32'd2, 32'hFFFF, SZ_HALF);
        check("out_half_hi", 32'(gout4), 32'h355);
        wr(A_OUT + 32'd1, 32'h0000, SZ_HALF);
        check("out_half_misal", 32'(gout4), 32'h355);
        wr(A_OUT, 32'hF0, SZ_BYTE);
        check("out_byte0", 32'(gout4), 32'h3F0);

        // SET / CLR.
        wr(A_OUT, 32'h0F0, SZ_WORD);
        wr(A_SET, 32'h00F, SZ_WORD);
        check("set", 32'(gout4), 32'h0FF);
        wr(A_CLR, 32'h0F0, SZ_WORD);
        check("clr", 32'(gout4), 32'h00F);
        rd(A_OUT, SZ_WORD, d, v);
        check("rd_out", d, 32'h00F);
        rd(A_SET, SZ_WORD, d, v);
        check("rd_set_data", d, 32'h0);
        check("rd_set_valid", 32'(v), 32'h1);
        @(negedge clk);
        check("valid_pulse", 32'(bus4.rdata_valid), 32'h0);
        rd(A_OUT, SZ_WORD, d, v);
        rd(A_OUT + 32'd2, SZ_WORD, d, v);
        check("rd_misal_data", d, 32'h0);
        check("rd_misal_valid", 32'(v), 32'h1);
        wr(A_OUT, 32'h2A5, SZ_WORD);
        rd(A_OUT + 32'd1, SZ_BYTE, d, v);
        check("rd_byte1", d, 32'h2);
        wr(A_OUT, 32'h00F, SZ_WORD);

        // Debounce: a 3-cycle glitch never produces two agreeing samples.
        gin4[0] = 1'b1;
        wait_cycles(3);
        gin4[0] = 1'b0;
        wait_cycles(12);
        rd(A_IN, SZ_WORD, d, v);
        check("glitch_in", d, 32'h0);
        rd(A_EDGE, SZ_WORD, d, v);
        check("glitch_edge", d, 32'h0);

        wr(A_IEN, 32'h001, SZ_WORD);
        check("irq_idle", 32'(irq4), 32'h0);
        gin4[0] = 1'b1;
        wait_cycles(12);
        rd(A_IN, SZ_WORD, d, v);
        check("level_in", d, 32'h001);
        rd(A_EDGE, SZ_WORD, d, v);
        check("level_edge", d, 32'h001);
        check("irq_rise", 32'(irq4), 32'h1);

        // W1C every cycle while the falling edge propagates: EDGE[0] can only end up
        // set if the edge beats the clear landing in the same cycle.
        gin4[0] = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wr(A_EDGE, 32'h001, SZ_WORD);
            if (irq4) begin
                found = 1'b1;
                break;
            end
        end
        check("race_irq", 32'(found), 32'h1);
        rd(A_EDGE, SZ_WORD, d, v);
        check("race_edge", d, 32'h001);
        rd(A_IN, SZ_WORD, d, v);
        check("race_in", d, 32'h0);
        check("race_irq_hold", 32'(irq4), 32'h1);
        wr(A_EDGE, 32'h001, SZ_WORD);
        check("w1c_irq", 32'(irq4), 32'h0);

        // Address decode.
        wr(32'h7FFF_FFFC, 32'h3FF, SZ_WORD);
        wr(32'h8000_0020, 32'h3FF, SZ_WORD);
        wr(A_RSV, 32'h3FF, SZ_WORD);
        check("decode_out", 32'(gout4), 32'h00F);
        rd(A_IEN, SZ_WORD, d, v);
        check("decode_ien", d, 32'h001);
        rd(A_RSV, SZ_WORD, d, v);
        check("rsv_data", d, 32'h0);
        check("rsv_valid", 32'(v), 32'h1);
        rd(32'h8000_0020, SZ_WORD, d, v);
        check("oow_valid", 32'(v), 32'h0);
        rd(32'h7FFF_FFFC, SZ_WORD, d, v);
        check("oow_low_valid", 32'(v), 32'h0);

        // Reset wins over a write in the same cycle.
        rst_n = 1'b0;
        wr(A_SET, 32'h3FF, SZ_WORD);
        rst_n = 1'b1;
        check("rst_prio_out", 32'(gout4), 32'h0);
        check("rst_prio_valid", 32'(bus4.rdata_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
